// File: rtl/s7_bin2bcd_ctrl.sv
// Binary-to-packed-BCD front end for the 7-segment display: valid/ready intake,
// serial double-dabble conversion, and an atomically updated BCD/blank/overflow result.
module s7_bin2bcd_ctrl #(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
    output logic [DISPLAYS_NUM-1:0]   o_blank_mask,
    output logic                      o_overflow,
    output logic                      o_done
);

    localparam int DIG_W = DISPLAYS_NUM * 4;
    localparam int CNT_W = $clog2(BIN_WIDTH) + 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(BIN_WIDTH - 1);
    localparam logic [DISPLAYS_NUM-1:0] MASK_RST = ~DISPLAYS_NUM'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [DIG_W-1:0]   digits;
    logic [DIG_W-1:0]   digits_adj;
    logic               ovf;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // Per-digit correction before each shift; digits never carry into each other.
    function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] r;
        r = d;
        for (int k = 0; k < DISPLAYS_NUM; k++) begin
            if (d[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = d[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [DIG_W-1:0] saturate(input logic [DIG_W-1:0] d, input logic ov);
        return ov ? {DISPLAYS_NUM{4'h9}} : d;
    endfunction

    // Digit 0 is always shown so a zero value still displays a single "0".
    function automatic logic [DISPLAYS_NUM-1:0] blank_mask(input logic [DIG_W-1:0] d,
                                                           input logic ov);
        logic [DISPLAYS_NUM-1:0] m;
        logic                    zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int k = DISPLAYS_NUM - 1; k >= 1; k--) begin
            zero_above = zero_above & (d[4*k +: 4] == 4'd0);
            m[k]       = zero_above & ~ov;
        end
        return m;
    endfunction

    assign o_ready    = (state == IDLE);
    assign accept     = i_valid & o_ready;
    assign digits_adj = add3(digits);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_sr <= '0;
            digits <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            bin_sr <= i_bin;
            digits <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            digits <= {digits_adj[DIG_W-2:0], bin_sr[BIN_WIDTH-1]};
            bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
            ovf    <= ovf | digits_adj[DIG_W-1];
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Output registers change only on the LOAD edge, so the display never sees partial digits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bcd_data   <= '0;
            o_blank_mask <= MASK_RST;
            o_overflow   <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= (state == LOAD);
            if (state == LOAD) begin
                o_bcd_data   <= saturate(digits, ovf);
                o_blank_mask <= blank_mask(digits, ovf);
                o_overflow   <= ovf;
            end
        end
    end

endmodule
